// File: rtl/router_pkg.sv
// Shared router definitions: default flit/port sizing, tail-flag position and
// a pointer-width helper used by the output arbiters.
package router_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_NUM_IN     = 4;
  localparam int unsigned TAIL_BIT       = DEF_DATA_WIDTH - 1;

  // Width of a binary index over n items, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((32'd1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching cyclically
// upward from ptr; returns a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Round-robin N:1 router output stage with a single registered output slot.
// Define OUTPUT_ARBITER_LOCK_EN to hold the output for one input until a tail flit.
module output_arbiter
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_IN     = DEF_NUM_IN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            in_full,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_re,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_we,
  input  logic                         down_full
);

  localparam int unsigned PTR_W = clog2(NUM_IN);

  logic                  out_valid;
  logic [PTR_W-1:0]      rr_ptr;
  logic [NUM_IN-1:0]     req;
  logic [NUM_IN-1:0]     gnt;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  slot_free;
  logic                  grant;
  logic [DATA_WIDTH-1:0] in_word [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign in_word[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef OUTPUT_ARBITER_LOCK_EN
  localparam int unsigned TAIL = DATA_WIDTH - 1;

  logic             lock_active;
  logic [PTR_W-1:0] lock_idx;

  always_comb begin
    req = in_full;
    if (lock_active) req = in_full & (NUM_IN'(1) << lock_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (grant) begin
      lock_active <= ~win_data[TAIL];
      lock_idx    <= win_idx;
    end
  end
`else
  assign req = in_full;
`endif

  rr_arbiter #(
    .N     (NUM_IN),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win_idx)
  );

  // A draining slot counts as free so it can be refilled in the same cycle.
  assign out_we    = out_valid & ~down_full;
  assign slot_free = ~out_valid | out_we;
  assign grant     = slot_free & (|req) & ~reset;
  assign in_re     = grant ? gnt : '0;
  assign win_data  = in_word[win_idx];
  assign next_ptr  = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_data  <= win_data;
      out_valid <= 1'b1;
      rr_ptr    <= next_ptr;
    end else if (out_we) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed-vector bench for output_arbiter (4 inputs, 64-bit flits); the lock
// scenario follows OUTPUT_ARBITER_LOCK_EN when defined.
module tb_output_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   in_full;
  logic [255:0] in_data;
  logic [3:0]   in_re;
  logic [63:0]  out_data;
  logic         out_we;
  logic         down_full;
  logic [63:0]  d [4];

  int unsigned n_vec;
  int unsigned n_bad;

  assign in_data = {d[3], d[2], d[1], d[0]};

  output_arbiter #(
    .DATA_WIDTH (64),
    .NUM_IN     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_full   (in_full),
    .in_data   (in_data),
    .in_re     (in_re),
    .out_data  (out_data),
    .out_we    (out_we),
    .down_full (down_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_full   = 4'b1111;
    down_full = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 64'hA0 + 64'(i);

    #1;
    check_vec("rst_in_re", 64'(in_re), 64'h0);
    check_vec("rst_out_we", 64'(out_we), 64'h0);
    check_vec("rst_out_data", out_data, 64'h0);
    tick();
    tick();
    check_vec("rst_hold_in_re", 64'(in_re), 64'h0);

    // release: rotation 0,1,2,3,0 with continuous drain
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_vec("rr_in_re", 64'(in_re), 64'(4'b0001 << (k % 4)));
      tick();
      check_vec("rr_out_data", out_data, d[k % 4]);
      check_vec("rr_out_we", 64'(out_we), 64'h1);
    end

    // backpressure with slot holding input 0's flit, pointer at 1
    down_full = 1'b1;
    #1;
    check_vec("bp_in_re", 64'(in_re), 64'h0);
    check_vec("bp_out_we", 64'(out_we), 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_vec("bp_hold_we", 64'(out_we), 64'h0);
      check_vec("bp_hold_re", 64'(in_re), 64'h0);
      check_vec("bp_hold_data", out_data, d[0]);
    end
    down_full = 1'b0;
    #1;
    check_vec("bp_rel_we", 64'(out_we), 64'h1);
    check_vec("bp_rel_re", 64'(in_re), 64'h2);
    tick();
    check_vec("bp_rel_data", out_data, d[1]);

    // pointer: at 2 -> grant 2 -> ptr 3 -> only input 1 wins -> ptr 2
    in_full = 4'b0100;
    #1;
    check_vec("ptr_g2_re", 64'(in_re), 64'h4);
    tick();
    check_vec("ptr_g2_data", out_data, d[2]);
    in_full = 4'b0010;
    #1;
    check_vec("ptr3_only1_re", 64'(in_re), 64'h2);
    tick();
    check_vec("ptr3_only1_data", out_data, d[1]);
    in_full = 4'b1010;
    #1;
    check_vec("ptr2_pick3_re", 64'(in_re), 64'h8);
    tick();
    check_vec("ptr2_pick3_data", out_data, d[3]);
    #1;
    check_vec("wrap_ptr0_re", 64'(in_re), 64'h2);
    in_full = 4'b0000;
    #1;
    check_vec("empty_re", 64'(in_re), 64'h0);
    tick();
    check_vec("drain_we", 64'(out_we), 64'h0);
    check_vec("drain_data_hold", out_data, d[3]);

    // asynchronous reset in mid-cycle with a loaded slot
    in_full = 4'b1111;
    #1;
    check_vec("pre_arst_re", 64'(in_re), 64'h1);
    tick();
    check_vec("pre_arst_data", out_data, d[0]);
    check_vec("pre_arst_we", 64'(out_we), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check_vec("arst_we", 64'(out_we), 64'h0);
    check_vec("arst_re", 64'(in_re), 64'h0);
    check_vec("arst_data", out_data, 64'h0);
    #1;
    reset = 1'b0;
    #1;
    check_vec("arst_ptr0_re", 64'(in_re), 64'h1);

    // packet from input 2 while input 0 waits; pointer reaches 3 after the head
    in_full = 4'b0100;
    d[2]    = 64'h0000_0000_0000_00A2;
    #1;
    check_vec("head_re", 64'(in_re), 64'h4);
    tick();
    check_vec("head_data", out_data, d[2]);
    in_full = 4'b0101;
`ifdef OUTPUT_ARBITER_LOCK_EN
    in_full = 4'b0001;
    #1;
    check_vec("lock_bubble_re", 64'(in_re), 64'h0);
    tick();
    check_vec("lock_bubble_we", 64'(out_we), 64'h0);
    in_full = 4'b0101;
    d[2]    = 64'h0000_0000_0000_00B2;
    #1;
    check_vec("lock_body_re", 64'(in_re), 64'h4);
    tick();
    check_vec("lock_body_data", out_data, 64'h0000_0000_0000_00B2);
    d[2] = 64'h8000_0000_0000_00C2;
    #1;
    check_vec("lock_tail_re", 64'(in_re), 64'h4);
    tick();
    check_vec("lock_tail_data", out_data, 64'h8000_0000_0000_00C2);
    #1;
    check_vec("unlock_in0_re", 64'(in_re), 64'h1);
    tick();
    check_vec("unlock_in0_data", out_data, d[0]);
`else
    #1;
    check_vec("nolock_in0_re", 64'(in_re), 64'h1);
    tick();
    check_vec("nolock_in0_data", out_data, d[0]);
    d[2] = 64'h8000_0000_0000_00C2;
    #1;
    check_vec("nolock_in2_re", 64'(in_re), 64'h4);
    tick();
    check_vec("nolock_tailbit_data", out_data, 64'h8000_0000_0000_00C2);
    #1;
    check_vec("nolock_wrap_re", 64'(in_re), 64'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Round-robin N:1 output stage of the router. It drains up to NUM_IN one-entry channel buffers: input-port buffers feeding one output direction, or NIC injection. Each winning flit goes into a single registered output slot, which writes into the downstream channel buffer on the link. It owns read-enable generation for its upstream buffers and write-enable generation for the downstream buffer.

## Interface
- DATA_WIDTH, 64, flit width in bits
- NUM_IN, 4, number of upstream buffers arbitrated (2..8)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_full  input  NUM_IN  full flag of each upstream channel buffer (1 = flit available)
- in_data  input  NUM_IN*DATA_WIDTH  data_out of each upstream buffer, input i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_re  output  NUM_IN  read enable to each upstream buffer, combinational, at most one bit high
- out_data  output  DATA_WIDTH  registered output slot contents
- out_we  output  1  write enable to downstream buffer
- down_full  input  1  full flag of downstream channel buffer

## Operation
- State:
  - Output slot: out_data plus out_valid.
  - Round-robin pointer rr_ptr, width clog2(NUM_IN).
  - With lock enabled, also lock_active and lock_idx.
- Drain: out_we = out_valid & ~down_full. The downstream buffer accepts exactly when out_we is high.
- Slot free this cycle: slot_free = ~out_valid | out_we. This allows a same-cycle drain and refill.
- Request vector:
  - Unlocked: req = in_full.
  - Locked: req = in_full & onehot(lock_idx).
- Grant: if slot_free and req != 0, pick the first set req bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... NUM_IN-1, 0, ...). Assert in_re[winner] in the same cycle.
- On grant, at the clock edge:
  - out_data <= in_data[winner]
  - out_valid <= 1
  - rr_ptr <= (winner+1) mod NUM_IN
- No grant but drain: out_valid <= 0. out_data holds its last value.
- No grant and no drain: all state holds.
- in_re is forced to 0 while reset is high. in_re is never asserted for an input whose in_full is 0.
- Upstream buffers give read priority over write, so a single input sustains at most 1 flit per 2 cycles. Two or more active inputs sustain 1 flit/cycle through the output.

## Timing
- Reset values: out_data=0, out_valid=0, out_we=0, in_re=0, rr_ptr=0, lock_active=0, lock_idx=0.
- Latency: in_re[i] at cycle t gives out_data valid at t+1. out_we at t+1 if down_full=0 at t+1.
- Backpressure: down_full=1 holds the slot. No new grant is made until the slot drains (slot_free=0 means in_re=0).
- Reset asserted mid-transfer: the slot is discarded, the pointer returns to 0, and any lock is dropped. Upstream buffers are reset by the same signal.
- Wrap-around: a grant to NUM_IN-1 sets rr_ptr=0.
- Simultaneous requests: the lowest index at or after rr_ptr (cyclically) wins. All others wait; no input waits more than NUM_IN grants.

## Configuration
- OUTPUT_ARBITER_LOCK_EN defined:
  - Bit DATA_WIDTH-1 of a flit is the tail flag.
  - A grant of a flit with tail=0 sets lock_active=1 and lock_idx=winner.
  - While locked, only lock_idx may be granted. Cycles where that input is empty are bubbles; rr_ptr does not advance.
  - A grant of a flit with tail=1 clears lock_active.
- OUTPUT_ARBITER_LOCK_EN undefined:
  - Per-flit round robin. The lock registers are not built.
  - Bit DATA_WIDTH-1 is ordinary payload.

## Structure
- The shared package router_pkg holds:
  - The default DATA_WIDTH and NUM_IN.
  - The TAIL_BIT position constant (DATA_WIDTH-1).
  - A clog2 helper function for pointer widths.
- One combinational sub-module, rr_arbiter (inputs req and ptr; output a one-hot grant plus the binary index). It is reused by the other router output ports.

## Test plan
- Reset with all inputs full, then release → first grant goes to input 0 (in_re=0001). out_data equals in_data[0] one cycle later and out_we=1.
- All four inputs held full and down_full=0 → grant order 0,1,2,3,0,… and one out_we per cycle after the first.
- Slot loaded, then down_full=1 for 5 cycles → out_we=0 and in_re=0 for all 5 cycles, out_data stable. On release, out_we=1 and a new grant occurs in the same cycle.
- rr_ptr=3, only input 1 full → input 1 granted and rr_ptr becomes 2. After a grant to input 3, rr_ptr=0.
- Reset asserted asynchronously mid-cycle while out_valid=1 → out_we and in_re drop immediately and out_data=0.
- Lock enabled: input 2 sends head (tail=0), then body (tail=0), then tail (tail=1), with input 0 full throughout → input 0 is not granted until the tail from input 2 has been granted. Then input 0 is granted.
